cba_pipe_sub: RTL and testbench



---
 rtl/cba_pipe_sub.sv | 193 +++++++++++++++++++
 tb/tb_cba_pipe_sub.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cba_pipe_sub.sv
// cba_pipe_sub: pipelined carry-bypass subtractor, diff = a - b - bin.
// The subtraction is carried out as a + ~b + ~bin, one carry-bypass block per
// register stage. Each stage carries forward the diff bits already resolved,
// the untouched upper bits of a and ~b, and the borrow out of its block.
// Valid/ready handshakes are provided on both sides, and empty stages (bubbles)
// are filled as soon as upstream data is available.
module cba_pipe_sub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  generate
    if (((WIDTH % BLOCK) != 0) || (WIDTH < BLOCK) || (BLOCK < 1)) begin : g_param_err
      $error("cba_pipe_sub: WIDTH must be a non-zero multiple of BLOCK");
    end
  endgenerate

  // Evaluate one carry-bypass block on a and inverted b.
  // Result layout: {ovf term, carry out, sum bits}. The ovf term is
  // (carry into the block MSB) ^ (block carry out). It is only meaningful
  // for the most significant block.
  function automatic logic [BLOCK+1:0] cba_block(
    input logic [BLOCK-1:0] a_blk,
    input logic [BLOCK-1:0] nb_blk,
    input logic             cin
  );
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] s;
    logic             c;
    logic             c_top;
    logic             all_p;
    logic             cout;
    c     = cin;
    c_top = cin;
    all_p = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      p[i]  = a_blk[i] ^ nb_blk[i];
      g[i]  = a_blk[i] & nb_blk[i];
      s[i]  = p[i] ^ c;
      c_top = c;
      c     = g[i] | (p[i] & c);
      all_p = all_p & p[i];
    end
    // When every bit propagates, the block input carry skips straight to the output.
    if (all_p) begin
      cout = cin;
    end else begin
      cout = c;
    end
    return {c_top ^ cout, cout, s};
  endfunction

  // Stage state.
  // x_q[k]: the low (k+1)*BLOCK bits hold resolved diff bits; the bits above hold a.
  // nb_q[k]: ~b, of which only the bits above stage k are still consumed.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [WIDTH-1:0]  x_q  [STAGES];
  logic [WIDTH-1:0]  x_d  [STAGES];
  logic [WIDTH-1:0]  nb_q [STAGES];
  logic [STAGES-1:0] bw_q;
  logic [STAGES-1:0] bw_d;
  logic              ovf_q;
  logic              ovf_d;

  // Per-stage sources, handshake terms and block results.
  logic [WIDTH-1:0]  src_x_s  [STAGES];
  logic [WIDTH-1:0]  src_nb_s [STAGES];
  logic [STAGES-1:0] src_bw_s;
  logic [STAGES-1:0] src_v_s;
  logic [STAGES-1:0] acc_s;
  logic [STAGES-1:0] load_s;
  logic [BLOCK+1:0]  blk_s [STAGES];
  logic              rdy_chain_s;
  logic              unused_s;

  // Select each stage's source: stage 0 takes the input port, later stages take the previous register.
  always_comb begin
    src_x_s[0]  = a;
    src_nb_s[0] = ~b;
    src_bw_s[0] = bin;
    src_v_s[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_x_s[k]  = x_q[k-1];
      src_nb_s[k] = nb_q[k-1];
      src_bw_s[k] = bw_q[k-1];
      src_v_s[k]  = v_q[k-1];
    end
  end

  // Ready chain from out_ready backwards: a stage accepts when it is empty or its content moves on.
  always_comb begin
    rdy_chain_s = out_ready;
    acc_s       = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy_chain_s = ~v_q[k] | rdy_chain_s;
      acc_s[k]    = rdy_chain_s;
    end
  end

  // Next valid bits and data-load enables for each stage.
  always_comb begin
    v_d    = v_q;
    load_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      if (acc_s[k]) begin
        v_d[k]    = src_v_s[k];
        load_s[k] = src_v_s[k];
      end else begin
        v_d[k]    = v_q[k];
        load_s[k] = 1'b0;
      end
    end
  end

  // Evaluate block k in stage k; splice its diff bits in and turn the block carry into a borrow.
  always_comb begin
    bw_d = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      blk_s[k] = cba_block(src_x_s[k][k*BLOCK +: BLOCK],
                           src_nb_s[k][k*BLOCK +: BLOCK],
                           ~src_bw_s[k]);
      x_d[k]                   = src_x_s[k];
      x_d[k][k*BLOCK +: BLOCK] = blk_s[k][BLOCK-1:0];
      bw_d[k]                  = ~blk_s[k][BLOCK];
    end
    ovf_d = blk_s[STAGES-1][BLOCK+1];
  end

  // Gather bits that have no consumer: the last stage's ~b copy and the ovf term of the lower blocks.
  always_comb begin
    unused_s = ^nb_q[STAGES-1];
    for (int k = 0; k < STAGES - 1; k++) begin
      unused_s = unused_s ^ blk_s[k][BLOCK+1];
    end
  end

  // Stage valid bits: cleared on reset, otherwise advanced along the ready chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= {STAGES{1'b0}};
    end else begin
      v_q <= v_d;
    end
  end

  // Stage data registers: cleared on reset, loaded only when a valid beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= {WIDTH{1'b0}};
        nb_q[k] <= {WIDTH{1'b0}};
      end
      bw_q  <= {STAGES{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_s[k]) begin
          x_q[k]  <= x_d[k];
          nb_q[k] <= src_nb_s[k];
          bw_q[k] <= bw_d[k];
        end
      end
      if (load_s[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  // While reset is held, in_ready stays low so that no beat appears to transfer.
  assign in_ready  = acc_s[0] & rst_n;
  assign out_valid = v_q[STAGES-1];
  assign diff      = x_q[STAGES-1];
  assign bout      = bw_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cba_pipe_sub.sv
// Testbench for cba_pipe_sub: a scoreboard queue is filled on input accept
// from an arithmetic reference model; a negedge monitor pops and compares
// on every output transfer.
module tb_cba_pipe_sub;

  localparam int W = 16;
  localparam int B = 4;
  localparam int NST = W / B;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         bin_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  bit   rand_rdy_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [W+1:0] prev_word = '0;

  cba_pipe_sub #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .bin       (bin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t r;
    int ua, ub, sa, sb, d, sd;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    d  = ua - ub - int'(bi);
    sd = sa - sb - int'(bi);
    r.diff = W'(d & 32'h0000_FFFF);
    r.bout = (ua < ub + int'(bi));
    r.ovf  = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  task automatic push_beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_q.push_back(model(av, bv, bi));
    n_sent++;
    last_acc_cyc = cyc;
  endtask

  // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    a_s = av;
    b_s = bv;
    bin_s = bi;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_beat(av, bv, bi);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) fail_now("send_accept");
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, then check the accept-to-output distance.
  task automatic wait_out(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (done) chk(name, cyc - last_acc_cyc, NST);
    else fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    rand_rdy_en = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Random consumer back-pressure.
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy_en) out_ready = ($urandom_range(0, 9) < 7);
  end

  // Monitor: compare every output transfer against the scoreboard; check stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", {diff, bout, ovf}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          mon_e = exp_q.pop_front();
          chk("diff", diff, mon_e.diff);
          chk("bout", bout, mon_e.bout);
          chk("ovf", ovf, mon_e.ovf);
          n_recv++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word = {diff, bout, ovf};
    end
  end

  // Global watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] bp_a [6];
  logic [W-1:0] bp_b [6];
  logic         bp_c [6];

  initial begin
    int k, accepted;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a_s = '0;
    b_s = '0;
    bin_s = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed values, first with the latency check.
    out_ready = 1'b1;
    send(16'h1234, 16'h0234, 1'b0);
    wait_out("latency_first");
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h0F0F, 16'h0F0F, 1'b0);
    send(16'h0F0F, 16'h0F0F, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Back-pressure: 6 beats offered with out_ready low for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
      bp_c[i] = 1'($urandom);
    end
    out_ready = 1'b0;
    k = 0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a_s = bp_a[k];
      b_s = bp_b[k];
      bin_s = bp_c[k];
      @(negedge clk);
      chk("bp_in_ready", in_ready, (accepted < NST));
      if (in_ready) begin
        push_beat(bp_a[k], bp_b[k], bp_c[k]);
        accepted++;
        k++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (k < 6) begin
        in_valid = 1'b1;
        a_s = bp_a[k];
        b_s = bp_b[k];
        bin_s = bp_c[k];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_stream_valid", out_valid, 1);
      if (in_valid && in_ready) begin
        push_beat(bp_a[k], bp_b[k], bp_c[k]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", k, 6);
    drain();

    // Reset with 3 beats in flight.
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b1);
    send(16'h0101, 16'h2020, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_ovf", ovf, 0);
    n_sent -= exp_q.size();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h5555, 16'h2222, 1'b1);
    wait_out("latency_after_reset");
    drain();

    // Random stream with random input gaps and output back-pressure.
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();
    repeat (5) @(negedge clk);
    chk("final_idle", out_valid, 0);
    chk("recv_count", n_recv, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
